// File: rtl/hr_dpwm_pkg.sv
// Shared defaults and duty-word helpers for the hybrid counter/delay-line DPWM.
package hr_dpwm_pkg;

  localparam int NC_DEF  = 4;
  localparam int NDE_DEF = 64;
  localparam int NF_DEF  = $clog2(NDE_DEF);

  typedef struct packed {
    logic [15:0] coarse;
    logic [15:0] fine;
  } duty_split_t;

  // Split a zero-extended duty word into its coarse (cycle) and fine (tap) fields.
  function automatic duty_split_t duty_split(input logic [31:0] duty, input int nf);
    duty_split_t s;
    s.coarse = 16'(duty >> nf);
    s.fine   = 16'(duty & ((32'd1 << nf) - 32'd1));
    return s;
  endfunction

endpackage

// File: rtl/dl_tap_mux.sv
// Nde:1 delay-line tap selector; kept as its own cell so placement can balance every tap path.
module dl_tap_mux
  import hr_dpwm_pkg::*;
#(
  parameter int  Nde = NDE_DEF,
  localparam int Nf  = $clog2(Nde)
) (
  input  logic [Nde-1:0] Delay,
  input  logic [Nf-1:0]  sel,
  output logic           tap
);

  assign tap = Delay[sel];

endmodule

// File: rtl/hr_dpwm_core.sv
// Hybrid DPWM: a coarse counter picks the cycle of the falling edge, a delay-line tap
// picks its position inside that cycle. Duty commands are double-buffered per period.
module hr_dpwm_core
  import hr_dpwm_pkg::*;
#(
  parameter int  Nc  = NC_DEF,
  parameter int  Nde = NDE_DEF,
  localparam int Nf  = $clog2(Nde)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Nc+Nf-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic [Nde-1:0]   Delay,
  output logic             pwm_out,
  output logic             period_start,
  output logic [Nc+Nf-1:0] duty_active
);

  localparam int DW = Nc + Nf;
  localparam logic [Nc-1:0] CNT_LAST = '1;

  function automatic logic [Nc-1:0] coarse_of(input logic [DW-1:0] d);
    duty_split_t s;
    s = duty_split(32'(d), Nf);
    return s.coarse[Nc-1:0];
  endfunction

  function automatic logic [Nf-1:0] fine_of(input logic [DW-1:0] d);
    duty_split_t s;
    s = duty_split(32'(d), Nf);
    return s.fine[Nf-1:0];
  endfunction

  logic [Nc-1:0] r_cnt;
  logic          r_run;
  logic          r_pwm_q;
  logic          r_match_q;
  logic          r_period_start;
  logic          r_pend_full;
  logic [DW-1:0] r_pend;
  logic [DW-1:0] r_active;

  logic          w_start;
  logic          w_accept;
  logic          w_xfer;
  logic [Nc-1:0] w_cnt_nxt;
  logic [DW-1:0] w_active_nxt;
  logic          w_tap;

  // A period starts on the wrap edge, or on the first enabled edge after en was low
  // (the counter then stays at 0 for that edge so the period is a full 2^Nc cycles).
  assign w_start = en && (!r_run || (r_cnt == CNT_LAST));

  // Handshake: a word transfers on every edge where duty_valid && duty_ready; duty_ready
  // is ~pend_full (registered, no path from duty_valid), and duty_in must stay stable
  // while duty_valid is held against duty_ready=0.
  assign w_accept = duty_valid && !r_pend_full;
  assign w_xfer   = (w_start || !en) && r_pend_full;

  assign w_cnt_nxt    = (!en || w_start) ? '0 : r_cnt + Nc'(1);
  assign w_active_nxt = w_xfer ? r_pend : r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_run          <= 1'b0;
      r_pwm_q        <= 1'b0;
      r_match_q      <= 1'b0;
      r_period_start <= 1'b0;
      r_pend_full    <= 1'b0;
      r_pend         <= '0;
      r_active       <= '0;
    end else begin
      r_run          <= en;
      r_cnt          <= w_cnt_nxt;
      r_period_start <= w_start;
      r_pend_full    <= w_accept || (r_pend_full && !w_xfer);
      if (w_accept) r_pend <= duty_in;
      if (w_xfer) r_active <= r_pend;
      r_match_q <= en && (w_cnt_nxt == coarse_of(w_active_nxt));
      // Set beats clear so an all-ones duty returns high at the wrap edge.
      if (!en) r_pwm_q <= 1'b0;
      else if (w_start) r_pwm_q <= (w_active_nxt != '0);
      else if (r_match_q) r_pwm_q <= 1'b0;
    end
  end

  dl_tap_mux #(
    .Nde (Nde)
  ) u_tap_mux (
    .Delay (Delay),
    .sel   (fine_of(r_active)),
    .tap   (w_tap)
  );

  assign pwm_out      = r_pwm_q & ~(r_match_q & w_tap);
  assign duty_ready   = ~r_pend_full;
  assign period_start = r_period_start;
  assign duty_active  = r_active;

endmodule
